line_derotator: RTL and testbench
=================================

# line_derotator

Descrambler half of the line-rotation scheme. It takes the scrambled BT.656 10-bit stream plus the per-line 8-bit cut position from the DRBG consumer, buffers one full line, and emits the line with its active region rotated back to the original order. It sits after `sync_parser` on the receive side, mirroring `line_rotator` on the transmit side, and adds exactly one line of delay.

## Interface
- `LINE_SIZE`, 1716: maximum samples per stored line (NTSC 2×858).
- `ACTIVE_LEN`, 1440: required active samples per line for derotation.
- `CUT_SHIFT`, 2: cut in samples = `raw_cut_position << CUT_SHIFT`, which keeps Cb-Y-Cr-Y alignment.

- `clk`  in  1  sample clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `data_in`  in  10  scrambled BT.656 sample.
- `raw_cut_position`  in  8  cut for the line currently being written.
- `H`  in  1  from `sync_parser`: 1 = horizontal blanking.
- `V`  in  1  from `sync_parser`: 1 = vertical blanking.
- `data_out`  out  10  descrambled sample.
- `data_out_valid`  out  1  `data_out` carries a buffered-line sample.
- `bad_line_count`  out  16  present only with `LINE_DEROTATOR_STATS_EN`.

## Operation
- **Line start:** the cycle where `H`=1 and the previous-cycle `H`=0 (EAV edge). `H_prev` resets to 1, so reset never creates a false edge.
- **Buffering:** two banks of `LINE_SIZE`×10 RAM, used ping-pong.
- **Writing:**
  - Write index `w` is 0 at line start and increments each cycle. It saturates at `LINE_SIZE-1`; extra samples overwrite the last entry.
  - On the first `H`=0 cycle of the line, latch `act_start`=`w`, `cut`=`raw_cut_position<<CUT_SHIFT`, and `v_line`=`V`.
  - Count `act_len` over `H`=0 cycles, saturating at 2047.
- **Bank swap at line start:**
  - The closing bank's metadata (`act_start`, `act_len`, `cut`, `v_line`) is frozen for reading.
  - The write bank toggles and read index `r` restarts at 0. `r` increments in lockstep with `w`.
- **Derotate condition:** `act_len`==`ACTIVE_LEN` and `v_line`==0. Otherwise the line passes through and `addr`=min(`r`, `LINE_SIZE-1`).
- **Remap when derotating:**
  - For `r` in [`act_start`, `act_start+ACTIVE_LEN`), let `j`=`r`−`act_start`.
  - `addr` = `act_start` + (`j`≥`cut` ? `j`−`cut` : `j`+`ACTIVE_LEN`−`cut`).
  - All other `r` values use `addr`=`r`, so EAV, SAV and blanking pass through unchanged.
  - `cut`≤1020<`ACTIVE_LEN`, so no further modulo is needed.
  - Arithmetic is 11-bit unsigned.
- **States:**
  - `IDLE`: after reset, wait for line start → `FILL`.
  - `FILL`: write the first line and read nothing; next line start → `RUN`.
  - `RUN`: write and read continuously. Only reset leaves `RUN`.
- Samples before the first line start after reset are discarded.
- A line whose `act_len`≠`ACTIVE_LEN` while `v_line`=0 is a bad line.

## Timing
- **Reset values:** `data_out`=10'h000, `data_out_valid`=0, state `IDLE`, both banks' metadata cleared, `bad_line_count`=0.
- RAM read is registered. `data_out` at cycle t is the sample at `addr(r)` from cycle t−1.
- **Pass-through latency:** a sample written at index k of line n appears at `data_out` one cycle after read index k of line n+1.
  - For constant line length L this is L+1 cycles.
- **`data_out_valid`:**
  - Rises the cycle after the line start that enters `RUN`, then stays 1 every cycle.
  - In `RUN` it does not gap between lines.
- A bank read and a bank write never target the same bank in one cycle.
- **Reset mid-line:** outputs clear immediately (asynchronous), the partial line is discarded, and operation restarts at `IDLE`.
- `raw_cut_position` changing outside the first `H`=0 cycle has no effect on that line.

## Configuration
- **`LINE_DEROTATOR_STATS_EN` defined:**
  - Adds the `bad_line_count` port, a saturating 16-bit counter.
  - It increments at the line start that closes a bad line and holds at 16'hFFFF.
- **Undefined:** the port and counter are absent. Datapath behaviour is identical.

## Test plan
- **Identity:** raw=0 on all lines, 1716-sample lines with 1440 active → output equals input delayed 1717 cycles; `data_out_valid` rises one cycle after the 2nd line start.
- **Cut 4:** raw=1, active samples S[i]=i → output active j=0 is 1436, j=3 is 1439, j=4 is 0, j=1439 is 1435.
- **Round trip:** `line_rotator` (MODE 0) feeding `line_derotator` with a shared per-line raw value (e.g. 0x7F, cut 508, then 0xFF, cut 1020) → recovered active samples are bit-exact with the original; EAV/SAV are unchanged.
- **Vertical blanking:** `V`=1 line with raw=0x40 → pass-through, no remap.
- **Bad line:** 1438 active samples with raw=0x10 → pass-through; with `LINE_DEROTATOR_STATS_EN` defined, `bad_line_count` goes 0→1 at the next line start.
- **Reset mid-line:** assert `reset_n`=0 at write index 800 in `RUN` → `data_out`=0 and `data_out_valid`=0 the same cycle; after release, valid returns only after two further line starts.

Source files
------------

// File: rtl/line_derotator_if.sv
// Signal bundle between the receive-side sync parser stage and line_derotator.
// bad_line_count exists only when LINE_DEROTATOR_STATS_EN is defined.
interface line_derotator_if;
    logic [9:0] data_in;
    logic [7:0] raw_cut_position;
    logic       H;
    logic       V;
    logic [9:0] data_out;
    logic       data_out_valid;
`ifdef LINE_DEROTATOR_STATS_EN
    logic [15:0] bad_line_count;

    modport master (
        output data_in, raw_cut_position, H, V,
        input  data_out, data_out_valid, bad_line_count
    );

    modport slave (
        input  data_in, raw_cut_position, H, V,
        output data_out, data_out_valid, bad_line_count
    );
`else
    modport master (
        output data_in, raw_cut_position, H, V,
        input  data_out, data_out_valid
    );

    modport slave (
        input  data_in, raw_cut_position, H, V,
        output data_out, data_out_valid
    );
`endif
endinterface

// File: rtl/line_derotator.sv
// Buffers one BT.656 line in ping-pong RAM and reads it back with the active region un-rotated.
// Optional bad-line statistics counter enabled by defining LINE_DEROTATOR_STATS_EN.
module line_derotator #(
    parameter int LINE_SIZE  = 1716,
    parameter int ACTIVE_LEN = 1440,
    parameter int CUT_SHIFT  = 2
) (
    input logic               clk,
    input logic               reset_n,
    line_derotator_if.slave   bus
);

    localparam logic [10:0] LAST    = 11'(LINE_SIZE - 1);
    localparam logic [10:0] ACT     = 11'(ACTIVE_LEN);
    localparam logic [10:0] LEN_SAT = 11'h7FF;

    typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

    state_t      state;
    logic        h_prev;
    logic        wb;
    logic [10:0] w_cnt;

    logic        wr_started;
    logic [10:0] wr_as;
    logic [10:0] wr_len;
    logic [10:0] wr_cut;
    logic        wr_v;

    logic [10:0] rd_as;
    logic [10:0] rd_len;
    logic [10:0] rd_cut;
    logic        rd_v;

    logic [9:0]  mem0 [LINE_SIZE];
    logic [9:0]  mem1 [LINE_SIZE];

    logic        line_start;
    logic [10:0] w_idx;
    logic        cur_wb;
    logic        wr_en;
    logic        rd_en;
    logic [10:0] eff_as;
    logic [10:0] eff_len;
    logic [10:0] eff_cut;
    logic        eff_v;
    logic [10:0] j;
    logic        in_active;
    logic        derot;
    logic [10:0] rem;
    logic [10:0] addr_raw;
    logic [10:0] addr;
    logic [9:0]  rd_word;
    logic        bad_close;

    // Read and write share one index; at a line start the just-closed line's
    // metadata is used directly because its frozen copy lands a cycle later.
    always_comb begin
        line_start = bus.H & ~h_prev;
        w_idx      = line_start ? 11'd0 : w_cnt;
        cur_wb     = line_start ? ~wb : wb;
        wr_en      = (state != IDLE) | line_start;
        rd_en      = (state == RUN) | ((state == FILL) & line_start);
        eff_as     = line_start ? wr_as  : rd_as;
        eff_len    = line_start ? wr_len : rd_len;
        eff_cut    = line_start ? wr_cut : rd_cut;
        eff_v      = line_start ? wr_v   : rd_v;
        j          = w_idx - eff_as;
        in_active  = (w_idx >= eff_as) && (j < ACT);
        derot      = (eff_len == ACT) && !eff_v;
        rem        = (j >= eff_cut) ? (j - eff_cut) : (j + ACT - eff_cut);
        addr_raw   = (derot && in_active) ? (eff_as + rem) : w_idx;
        addr       = (addr_raw > LAST) ? LAST : addr_raw;
        rd_word    = cur_wb ? mem0[addr] : mem1[addr];
        bad_close  = line_start && (state != IDLE) && (wr_len != ACT) && !wr_v;
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (cur_wb) mem1[w_idx] <= bus.data_in;
            else        mem0[w_idx] <= bus.data_in;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state              <= IDLE;
            h_prev             <= 1'b1;
            wb                 <= 1'b0;
            w_cnt              <= '0;
            wr_started         <= 1'b0;
            wr_as              <= '0;
            wr_len             <= '0;
            wr_cut             <= '0;
            wr_v               <= 1'b0;
            rd_as              <= '0;
            rd_len             <= '0;
            rd_cut             <= '0;
            rd_v               <= 1'b0;
            bus.data_out       <= '0;
            bus.data_out_valid <= 1'b0;
`ifdef LINE_DEROTATOR_STATS_EN
            bus.bad_line_count <= '0;
`endif
        end else begin
            case (state)
                IDLE:    if (line_start) state <= FILL;
                FILL:    if (line_start) state <= RUN;
                default: state <= RUN;
            endcase

            h_prev <= bus.H;
            wb     <= cur_wb;
            w_cnt  <= (w_idx == LAST) ? LAST : (w_idx + 11'd1);

            // Cut and V are sampled only on the first active cycle of each line.
            if (line_start) begin
                rd_as      <= wr_as;
                rd_len     <= wr_len;
                rd_cut     <= wr_cut;
                rd_v       <= wr_v;
                wr_started <= 1'b0;
                wr_as      <= '0;
                wr_len     <= '0;
                wr_cut     <= '0;
                wr_v       <= 1'b0;
            end else if (!bus.H) begin
                if (!wr_started) begin
                    wr_started <= 1'b1;
                    wr_as      <= w_idx;
                    wr_cut     <= 11'(bus.raw_cut_position) << CUT_SHIFT;
                    wr_v       <= bus.V;
                end
                if (wr_len != LEN_SAT) wr_len <= wr_len + 11'd1;
            end

            bus.data_out       <= rd_en ? rd_word : 10'h000;
            bus.data_out_valid <= rd_en;
`ifdef LINE_DEROTATOR_STATS_EN
            if (bad_close && (bus.bad_line_count != 16'hFFFF))
                bus.bad_line_count <= bus.bad_line_count + 16'd1;
`endif
        end
    end

endmodule

// File: tb/tb_line_derotator.sv
// Directed line-by-line bench for line_derotator: a table of line records drives
// the stream, expected output comes from the bench's own copy of each written line.
module tb_line_derotator;

    localparam int LS = 1716;
    localparam int AL = 1440;

    typedef struct {
        logic [7:0] raw;
        logic       v;
        int         act_n;
        int         seed;
        logic       derot;
        logic       bad;
        int         pj0;
        logic [9:0] pv0;
        int         pj1;
        logic [9:0] pv1;
    } line_vec_t;

    line_vec_t vecs [12];

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    line_derotator_if bus_if ();

    line_derotator dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_if)
    );

    int         n_checks = 0;
    int         n_pass   = 0;
    int         starts;
    logic       h_prev_m;
    logic [9:0] cur_buf  [LS];
    logic [9:0] prev_buf [LS];
    int         cur_vi;
    int         prev_vi;
    logic       exp_valid;
    logic [9:0] exp_data;
    logic       exp_probe_en;
    logic [9:0] exp_probe;
    int         exp_bad;

    task automatic compare(input string name, input logic [15:0] act, input logic [15:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("[TB] FAIL %s at t=%0t: got %0h, expected %0h", name, $time, act, req);
    endtask

    function automatic logic [9:0] sample_of(input int vi, input int k);
        int as_l;
        as_l = LS - vecs[vi].act_n;
        if (k < as_l) return 10'((k * 5 + vecs[vi].seed * 3) & 'h3FF);
        return 10'((vecs[vi].seed + k - as_l) & 'h3FF);
    endfunction

    function automatic int exp_addr(input int vi, input int r);
        int as_l;
        int cut;
        int jj;
        as_l = LS - vecs[vi].act_n;
        cut  = int'(vecs[vi].raw) * 4;
        if (vecs[vi].derot && r >= as_l && r < as_l + AL) begin
            jj = r - as_l;
            return as_l + ((jj >= cut) ? (jj - cut) : (jj + AL - cut));
        end
        return (r > LS - 1) ? LS - 1 : r;
    endfunction

    task automatic checkOutput();
        compare("valid", 16'(bus_if.data_out_valid), 16'(exp_valid));
        if (exp_valid) compare("data", 16'(bus_if.data_out), 16'(exp_data));
        if (exp_probe_en) compare("probe", 16'(bus_if.data_out), 16'(exp_probe));
`ifdef LINE_DEROTATOR_STATS_EN
        compare("bad_line_count", bus_if.bad_line_count, 16'(exp_bad));
`endif
    endtask

    // Drives one line (or its first stop_at samples) and predicts the output of every cycle.
    task automatic applyStimulus(input int vi, input int stop_at);
        int   as_l;
        int   pas;
        logic h;
        for (int k = 0; k < stop_at; k++) begin
            @(posedge clk);
            #1;
            checkOutput();
            as_l = LS - vecs[vi].act_n;
            h    = (k < as_l);
            bus_if.H                = h;
            bus_if.V                = vecs[vi].v;
            bus_if.data_in          = sample_of(vi, k);
            bus_if.raw_cut_position = (k == as_l) ? vecs[vi].raw : 8'hA5;
            if (h && !h_prev_m) begin
                if (starts >= 1 && cur_vi >= 0 && vecs[cur_vi].bad) exp_bad++;
                starts++;
                prev_buf = cur_buf;
                prev_vi  = cur_vi;
                cur_vi   = vi;
            end
            h_prev_m = h;
            if (starts >= 1) cur_buf[k] = bus_if.data_in;
            exp_valid    = (starts >= 2);
            exp_probe_en = 1'b0;
            if (exp_valid && prev_vi >= 0) begin
                exp_data = prev_buf[exp_addr(prev_vi, k)];
                pas      = LS - vecs[prev_vi].act_n;
                if (vecs[prev_vi].pj0 >= 0 && k == pas + vecs[prev_vi].pj0) begin
                    exp_probe_en = 1'b1;
                    exp_probe    = vecs[prev_vi].pv0;
                end
                if (vecs[prev_vi].pj1 >= 0 && k == pas + vecs[prev_vi].pj1) begin
                    exp_probe_en = 1'b1;
                    exp_probe    = vecs[prev_vi].pv1;
                end
            end
        end
    endtask

    task automatic reset_model();
        starts       = 0;
        h_prev_m     = 1'b1;
        cur_vi       = -1;
        prev_vi      = -1;
        exp_valid    = 1'b0;
        exp_probe_en = 1'b0;
        exp_data     = '0;
        exp_probe    = '0;
        exp_bad      = 0;
    endtask

    initial begin
        //               raw    v     act_n seed derot bad   pj0   pv0     pj1   pv1
        vecs[0]  = '{8'h00, 1'b0, 1440,  9, 1'b1, 1'b0,   -1, 10'd0,    -1, 10'd0};
        vecs[1]  = '{8'h00, 1'b0, 1440,  0, 1'b1, 1'b0,    5, 10'd5,  1439, 10'd415};
        vecs[2]  = '{8'h01, 1'b0, 1440,  0, 1'b1, 1'b0,    0, 10'd412, 1439, 10'd411};
        vecs[3]  = '{8'h7F, 1'b0, 1440, 100, 1'b1, 1'b0,   0, 10'd8,   508, 10'd100};
        vecs[4]  = '{8'hFF, 1'b0, 1440,  3, 1'b1, 1'b0,    0, 10'd423, 1020, 10'd3};
        vecs[5]  = '{8'h40, 1'b1, 1440,  0, 1'b0, 1'b0,    0, 10'd0,   300, 10'd300};
        vecs[6]  = '{8'h10, 1'b0, 1438,  0, 1'b0, 1'b1,    0, 10'd0,   100, 10'd100};
        vecs[7]  = '{8'h20, 1'b0, 1440, 40, 1'b1, 1'b0,    0, 10'd328, 128, 10'd40};
        vecs[8]  = '{8'h00, 1'b0, 1440,  7, 1'b1, 1'b0,   -1, 10'd0,    -1, 10'd0};
        vecs[9]  = '{8'h03, 1'b0, 1440, 13, 1'b1, 1'b0,   -1, 10'd0,    -1, 10'd0};
        vecs[10] = '{8'h02, 1'b0, 1440, 11, 1'b1, 1'b0,    0, 10'd419,   8, 10'd11};
        vecs[11] = '{8'h00, 1'b0, 1440, 20, 1'b1, 1'b0,   -1, 10'd0,    -1, 10'd0};

        reset_model();
        reset_n                 = 1'b0;
        bus_if.H                = 1'b1;
        bus_if.V                = 1'b0;
        bus_if.data_in          = '0;
        bus_if.raw_cut_position = '0;
        #12;
        compare("reset_data", 16'(bus_if.data_out), 16'h0000);
        compare("reset_valid", 16'(bus_if.data_out_valid), 16'h0000);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        for (int vi = 0; vi < 8; vi++) applyStimulus(vi, LS);

        // Reset in the middle of a RUN line must clear outputs without a clock edge.
        applyStimulus(8, 800);
        @(posedge clk);
        #1;
        checkOutput();
        #2;
        reset_n = 1'b0;
        #1;
        compare("midline_reset_data", 16'(bus_if.data_out), 16'h0000);
        compare("midline_reset_valid", 16'(bus_if.data_out_valid), 16'h0000);
        reset_model();
        bus_if.H = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;

        for (int vi = 9; vi < 12; vi++) applyStimulus(vi, LS);
        @(posedge clk);
        #1;
        checkOutput();

        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
